// File: rtl/toggle_scheduler.sv
// Toggle scheduler: issues a programmed number of T-enable pulses
// separated by a programmable idle gap and tracks the downstream Q.
module toggle_scheduler #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             T,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_left,
    output logic             q_expect
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] C_GAP_ZERO = '0;
    localparam logic [GAP_W-1:0] C_GAP_ONE  = GAP_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_left;
    logic [GAP_W-1:0] r_gap_lat;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_q;
    logic             r_t;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_next;
    logic             w_accept;
    logic             w_last;
    logic             w_gap_end;

    // A start is only honoured while idle; abort never overrides it there.
    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_left == C_CNT_ONE);
    // Treat a zero count as "expired" so GAP can never stall.
    assign w_gap_end = (r_gap_cnt <= C_GAP_ONE);

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (count == C_CNT_ZERO) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end else if (r_gap_lat == C_GAP_ZERO) begin
                    w_next = S_PULSE;
                end else begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_gap_end) begin
                    w_next = S_PULSE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register with output flags registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_t     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_t     <= (w_next == S_PULSE);
            r_busy  <= (w_next == S_PULSE) || (w_next == S_GAP);
            r_done  <= (w_next == S_DONE);
        end
    end

    // Command latch: count and gap are captured only on an accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gap_lat <= C_GAP_ZERO;
        end else if (w_accept) begin
            r_gap_lat <= gap;
        end
    end

    // Remaining-pulse counter; cleared by abort, never wraps below zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_left <= C_CNT_ZERO;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_left <= count;
                    end
                end
                S_PULSE: begin
                    if (abort) begin
                        r_left <= C_CNT_ZERO;
                    end else if (r_left != C_CNT_ZERO) begin
                        r_left <= r_left - C_CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        r_left <= C_CNT_ZERO;
                    end
                end
                default: begin
                    r_left <= r_left;
                end
            endcase
        end
    end

    // Idle-gap counter: loaded on leaving PULSE towards GAP, counts down in GAP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gap_cnt <= C_GAP_ZERO;
        end else begin
            unique case (r_state)
                S_PULSE: begin
                    if (w_next == S_GAP) begin
                        r_gap_cnt <= r_gap_lat;
                    end
                end
                S_GAP: begin
                    if (abort || (r_gap_cnt == C_GAP_ZERO)) begin
                        r_gap_cnt <= C_GAP_ZERO;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - C_GAP_ONE;
                    end
                end
                default: begin
                    r_gap_cnt <= r_gap_cnt;
                end
            endcase
        end
    end

    // Predicted downstream Q: every PULSE cycle is a real toggle, abort or not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= 1'b0;
        end else if (r_state == S_PULSE) begin
            r_q <= ~r_q;
        end
    end

    assign T           = r_t;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pulses_left = r_left;
    assign q_expect    = r_q;

endmodule

// File: tb/tb_toggle_scheduler.sv
// Scoreboard bench for toggle_scheduler: a driver pushes expected sequence
// summaries, a negedge monitor measures each finished sequence and compares.
module tb_toggle_scheduler;

    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             T;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_left;
    logic             q_expect;

    toggle_scheduler #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .count      (count),
        .gap        (gap),
        .abort      (abort),
        .T          (T),
        .busy       (busy),
        .done       (done),
        .pulses_left(pulses_left),
        .q_expect   (q_expect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int d;
        int nbusy;
        int nt;
        int q;
        int left;
        int first_left;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   mq       = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: a sequence of N pulses with gap G is a busy window of
    // N+(N-1)*G cycles where every (G+1)-th cycle, from the first, is a pulse.
    // An abort at busy index k truncates the window after cycle k.
    function automatic exp_t model(input int n, input int g, input int k);
        exp_t e;
        int   len;
        e.left = 0;
        if (n == 0) begin
            e.d = 1; e.nbusy = 0; e.nt = 0; e.first_left = -1;
        end else begin
            len = n + (n - 1) * g;
            e.first_left = n;
            if (k >= 0 && k < len) begin
                e.d = 0;
                e.nbusy = k + 1;
                e.nt = 0;
                for (int i = 0; i <= k; i++)
                    if (i % (g + 1) == 0) e.nt++;
            end else begin
                e.d = 1; e.nbusy = len; e.nt = n;
            end
        end
        e.q = 0;
        return e;
    endfunction

    task automatic push_exp(input int n, input int g, input int k);
        exp_t e;
        e = model(n, g, k);
        mq = mq ^ e.nt[0];
        e.q = int'(mq);
        sb.push_back(e);
    endtask

    // Runs one command; called at #1 after a rising edge with the DUT idle.
    // spur: 0 none, 1 random stray starts, 2 stray start with count=7 every busy cycle.
    task automatic run_seq(input int n, input int g, input int k,
                           input int spur, input bit abort_with_start);
        int len;
        count = CNT_W'(n);
        gap   = GAP_W'(g);
        start = 1'b1;
        abort = abort_with_start;
        push_exp(n, g, k);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        len = (n == 0) ? 0 : n + (n - 1) * g;
        for (int idx = 0; idx < len; idx++) begin
            abort = (idx == k);
            if (spur == 2) begin
                start = 1'b1; count = CNT_W'(7); gap = GAP_W'(0);
            end else if (spur == 1 && $urandom_range(0, 2) == 0) begin
                start = 1'b1;
                count = CNT_W'($urandom_range(0, 255));
                gap   = GAP_W'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (idx == k) break;
        end
        start = 1'b0;
        abort = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        abort = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    int  m_busy = 0;
    int  m_t = 0;
    int  m_first = -1;
    bit  m_prev_busy = 1'b0;

    // Monitor: measures each sequence and compares at its end (done or abort).
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            m_busy = 0; m_t = 0; m_first = -1; m_prev_busy = 1'b0;
        end else begin
            if (T) check("t_implies_busy", int'(busy), 1);
            if (busy) begin
                if (m_busy == 0) m_first = int'(pulses_left);
                m_busy++;
                if (T) m_t++;
            end
            if (done || (m_prev_busy && !busy)) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_end: got done=%0d busy_cycles=%0d expected no sequence end at %0t",
                             done, m_busy, $time);
                end else begin
                    e = sb.pop_front();
                    check("done_flag", int'(done), e.d);
                    check("busy_cycles", m_busy, e.nbusy);
                    check("t_cycles", m_t, e.nt);
                    check("q_expect", int'(q_expect), e.q);
                    check("pulses_left_end", int'(pulses_left), e.left);
                    check("pulses_left_first", m_first, e.first_left);
                end
                m_busy = 0; m_t = 0; m_first = -1;
            end
            m_prev_busy = busy;
        end
    end

    initial begin
        int n, g, k, len;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        count = '0;
        gap   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_T", int'(T), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_left", int'(pulses_left), 0);
        check("rst_q", int'(q_expect), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_seq(3, 0, -1, 0, 1'b0);
        run_seq(2, 2, -1, 0, 1'b0);
        run_seq(0, 0, -1, 0, 1'b0);
        run_seq(5, 1, 2, 0, 1'b0);
        run_seq(3, 2, -1, 2, 1'b0);
        run_seq(4, 3, -1, 0, 1'b1);
        run_seq(255, 0, -1, 0, 1'b0);
        run_seq(1, 15, -1, 0, 1'b0);
        run_seq(6, 2, 3, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            g = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
            len = (n == 0) ? 0 : n + (n - 1) * g;
            k = (n != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            run_seq(n, g, k, 1, 1'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of a PULSE cycle.
        count = CNT_W'(5);
        gap   = GAP_W'(0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("pulse_before_reset", int'(T), 1);
        #1;
        reset = 1'b0;
        sb.delete();
        mq = 1'b0;
        #1;
        check("mid_rst_T", int'(T), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_left", int'(pulses_left), 0);
        check("mid_rst_q", int'(q_expect), 0);

        // Release with start already high: accepted on the first edge.
        @(posedge clk); #1;
        count = CNT_W'(3);
        gap   = GAP_W'(1);
        start = 1'b1;
        push_exp(3, 1, -1);
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_after_release", int'(T), 1);
        repeat (10) @(posedge clk);
        #1;

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
